// File: rtl/mul_pipe_pkg.sv
// rtl/mul_pipe_pkg.sv - shared RV32M multiply op codes
package mul_pipe_pkg;

   localparam int MUL_OP_W = 2;

   localparam logic [MUL_OP_W-1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MULHU  = 2'b11;

endpackage

// File: rtl/mul_operand_ext.sv
// rtl/mul_operand_ext.sv - op-driven XLEN to XLEN+1 operand extension
module mul_operand_ext
   import mul_pipe_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic [MUL_OP_W-1:0] op,
   input  logic [XLEN-1:0]     a,
   input  logic [XLEN-1:0]     b,
   output logic [XLEN:0]       a_ext,
   output logic [XLEN:0]       b_ext
);

   logic a_signed;
   logic b_signed;

   assign a_signed = (op != MUL_OP_MULHU);
   assign b_signed = (op == MUL_OP_MUL) || (op == MUL_OP_MULH);

   assign a_ext = {a_signed & a[XLEN-1], a};
   assign b_ext = {b_signed & b[XLEN-1], b};

endmodule

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - pipelined RV32M multiply unit with valid/ready and flush
module mul_pipe
   import mul_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 5
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [MUL_OP_W-1:0] op_i,
   input  logic [XLEN-1:0]     a_i,
   input  logic [XLEN-1:0]     b_i,
   input  logic [TAG_W-1:0]    tag_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [XLEN-1:0]     res_o,
   output logic [TAG_W-1:0]    tag_o,
   output logic                busy_o
);

   typedef struct packed {
      logic                valid;
      logic [MUL_OP_W-1:0] op;
      logic [2*XLEN-1:0]   prod;
      logic [TAG_W-1:0]    tag;
   } slot_t;

   logic [XLEN:0]     a_ext;
   logic [XLEN:0]     b_ext;
   logic [2*XLEN-1:0] a_wide;
   logic [2*XLEN-1:0] b_wide;
   logic [2*XLEN-1:0] product;
   logic              stall;
   slot_t             in_slot;
   slot_t             slot_q [1:STAGES];

   mul_operand_ext #(.XLEN(XLEN)) u_operand_ext (
      .op    (op_i),
      .a     (a_i),
      .b     (b_i),
      .a_ext (a_ext),
      .b_ext (b_ext)
   );

   // Only 2*XLEN product bits survive, so multiplying the sign-extended operands
   // modulo 2^(2*XLEN) yields the same bits as the full signed product.
   assign a_wide  = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
   assign b_wide  = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
   assign product = a_wide * b_wide;

   assign stall      = slot_q[STAGES].valid & ~out_ready_i;
   assign in_ready_o = ~stall;

   always_comb begin
      in_slot       = '0;
      in_slot.valid = in_valid_i & in_ready_o;
      in_slot.op    = op_i;
      in_slot.prod  = product;
      in_slot.tag   = tag_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i <= STAGES; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         if (!stall) begin
            slot_q[1] <= in_slot;
            for (int i = 2; i <= STAGES; i++) begin
               slot_q[i] <= slot_q[i-1];
            end
         end
         // Flush overrides both the shift and the hold of every valid bit.
         if (flush_i) begin
            for (int i = 1; i <= STAGES; i++) begin
               slot_q[i].valid <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int i = 1; i <= STAGES; i++) begin
         busy_o = busy_o | slot_q[i].valid;
      end
   end

   assign out_valid_o = slot_q[STAGES].valid;
   assign tag_o       = slot_q[STAGES].tag;
   assign res_o       = (slot_q[STAGES].op == MUL_OP_MUL) ? slot_q[STAGES].prod[XLEN-1:0]
                                                          : slot_q[STAGES].prod[2*XLEN-1:XLEN];

endmodule
